// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//
// Multi-port register file for the datapath: DEPTH x DATA_W flop storage,
// N_RD combinational read ports and two clocked write ports (port B wins
// when both target the same register). Optionally bypasses in-flight write
// data to the read ports and hardwires register 0 to zero. A per-register
// dirty mask records which registers were written since the last clear.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high; clears storage and dirty mask
//   rd_addr    N_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    N_RD packed read data,      port k at [k*DATA_W +: DATA_W]
//   wa_en/wa_addr/wa_data   write port A (lower priority)
//   wb_en/wb_addr/wb_data   write port B (higher priority)
//   clr_dirty  clears every dirty bit at the next edge
//   dirty      bit i set when register i was written since last clear/reset
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter  int DATA_W   = 8,
  parameter  int ADDR_W   = 3,
  parameter  int N_RD     = 2,
  parameter  int BYPASS   = 0,
  parameter  int ZERO_REG = 0,
  localparam int DEPTH    = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     clr_dirty,
  output logic [DEPTH-1:0]         dirty
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  dirty_q;
  logic [DEPTH-1:0]  dirty_d;
  logic [DEPTH-1:0]  written;

  // Writes are ignored while reset is high, so an in-flight write is neither
  // stored nor visible through the bypass path during reset.
  logic wa_live;
  logic wb_live;
  assign wa_live = wa_en && !reset;
  assign wb_live = wb_en && !reset;

  // Effective writes after masking the hardwired-zero register.
  logic wa_eff;
  logic wb_eff;
  assign wa_eff = wa_live && ((ZERO_REG == 0) || (wa_addr != '0));
  assign wb_eff = wb_live && ((ZERO_REG == 0) || (wb_addr != '0));

  // -------------------------------------------------------------------------
  // Next-state: port A applied first, port B second so B overrides A on an
  // address collision.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before any condition;
    // a path that leaves one unassigned would infer a latch.
    regs_d  = regs_q;
    written = '0;
    if (wa_eff) begin
      regs_d[wa_addr]  = wa_data;
      written[wa_addr] = 1'b1;
    end
    if (wb_eff) begin
      regs_d[wb_addr]  = wb_data;
      written[wb_addr] = 1'b1;
    end
    // A write in the same cycle as clr_dirty leaves its bit set.
    dirty_d = (dirty_q & ~{DEPTH{clr_dirty}}) | written;
  end

  // -------------------------------------------------------------------------
  // State registers.
  // NOTE: storage is plain flops rather than an inferred RAM because reset
  // must clear every entry; a RAM macro has no reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      dirty_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs_q  <= regs_d;
      dirty_q <= dirty_d;
    end
  end

  assign dirty = dirty_q;

  // -------------------------------------------------------------------------
  // Read ports: purely combinational, each independent of the others.
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs_q[addr];
      if (BYPASS != 0) begin
        // Same priority as the write path: B's data wins over A's.
        if (wb_live && (wb_addr == addr)) begin
          data = wb_data;
        end else if (wa_live && (wa_addr == addr)) begin
          data = wa_data;
        end
      end
      // Register 0 reads zero even when a write to it is being bypassed.
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
//
// Four instances of reg_file_mp driven by the same stimulus:
//   u_plain  BYPASS=0 ZERO_REG=0
//   u_byp    BYPASS=1 ZERO_REG=0
//   u_zero   BYPASS=0 ZERO_REG=1
//   u_bz     BYPASS=1 ZERO_REG=1
// Expected values are pushed to a scoreboard queue when stimulus is driven
// and popped when the corresponding output is sampled.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int NR    = 2;
  localparam int DEPTH = 8;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic          wa_en     = 1'b0;
  logic [AW-1:0] wa_addr   = '0;
  logic [DW-1:0] wa_data   = '0;
  logic          wb_en     = 1'b0;
  logic [AW-1:0] wb_addr   = '0;
  logic [DW-1:0] wb_data   = '0;
  logic          clr_dirty = 1'b0;

  logic [NR*DW-1:0] rd_p, rd_b, rd_z, rd_bz;
  logic [DEPTH-1:0] dt_p, dt_b, dt_z, dt_bz;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(0), .ZERO_REG(0)) u_plain (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_p),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .clr_dirty(clr_dirty), .dirty(dt_p));

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(1), .ZERO_REG(0)) u_byp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .clr_dirty(clr_dirty), .dirty(dt_b));

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(0), .ZERO_REG(1)) u_zero (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_z),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .clr_dirty(clr_dirty), .dirty(dt_z));

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(1), .ZERO_REG(1)) u_bz (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_bz),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .clr_dirty(clr_dirty), .dirty(dt_bz));

  // Advance to 1 time unit after the next rising edge (clk is then high).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    wa_en     = 1'b0;
    wb_en     = 1'b0;
    clr_dirty = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    step();
    exp_q.push_back('{"rst_plain_rd", 32'h0});
    exp_q.push_back('{"rst_plain_dirty", 32'h0});
    exp_q.push_back('{"rst_zero_dirty", 32'h0});
    e = exp_q.pop_front(); total++; if (32'(rd_p) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p, e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_p) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_p, e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_z) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_z, e.val); end
    reset = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_bypass();
    step();
    // wb writing reg 4 (currently 0); bypass instance sees it before the edge.
    rd_addr = {3'd0, 3'd4};
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'hAB;
    exp_q.push_back('{"byp_wb_pre", 32'hAB});
    exp_q.push_back('{"nobyp_wb_pre", 32'h00});
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_b[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_b[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
    step();
    // Both ports on reg 4: B's data must be what the bypass returns.
    wa_en = 1'b1; wa_addr = 3'd4; wa_data = 8'h11;
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h22;
    exp_q.push_back('{"byp_ab_pre", 32'h22});
    exp_q.push_back('{"nobyp_ab_pre", 32'hAB});
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_b[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_b[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
    step();
    idle_writes();
    exp_q.push_back('{"byp_ab_post", 32'h22});
    exp_q.push_back('{"nobyp_ab_post", 32'h22});
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_b[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_b[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_basic();
    clr_dirty = 1'b1;
    step();
    clr_dirty = 1'b0;
    wa_en = 1'b1; wa_addr = 3'd3; wa_data = 8'd42;
    exp_q.push_back('{"basic_rd0", 32'd42});
    exp_q.push_back('{"basic_rd1", 32'd0});
    exp_q.push_back('{"basic_dirty", 32'h08});
    step();
    idle_writes();
    rd_addr = {3'd0, 3'd3};
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0])  !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_p[15:8]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[15:8], e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_p)       !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_p, e.val); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_conflict();
    wa_en = 1'b1; wa_addr = 3'd5; wa_data = 8'd99;
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 8'd100;
    exp_q.push_back('{"conf_same_r5", 32'd100});
    step();
    wa_addr = 3'd1; wa_data = 8'd7;
    wb_addr = 3'd2; wb_data = 8'd9;
    rd_addr = {3'd0, 3'd5};
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
    exp_q.push_back('{"conf_diff_r1", 32'd7});
    exp_q.push_back('{"conf_diff_r2", 32'd9});
    exp_q.push_back('{"conf_dirty", 32'h2E});
    step();
    idle_writes();
    rd_addr = {3'd2, 3'd1};
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0])  !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_p[15:8]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[15:8], e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_p)       !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_p, e.val); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_zero_reg();
    rd_addr = {3'd0, 3'd0};
    wa_en = 1'b1; wa_addr = 3'd0; wa_data = 8'hFF;
    // Before the edge: bypass without zero-reg shows FF, with zero-reg shows 0.
    exp_q.push_back('{"zero_byp_pre", 32'h00});
    exp_q.push_back('{"nozero_byp_pre", 32'hFF});
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_bz[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_bz[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_b[7:0])  !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_b[7:0], e.val); end
    exp_q.push_back('{"zero_rd", 32'h00});
    exp_q.push_back('{"zero_dirty", 32'h2E});
    exp_q.push_back('{"nozero_rd", 32'hFF});
    exp_q.push_back('{"nozero_dirty", 32'h2F});
    step();
    idle_writes();
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_z[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_z[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_z)      !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_z, e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_p)      !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_p, e.val); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      wa_en = 1'b1; wa_addr = AW'(i); wa_data = DW'(i + 10);
      step();
    end
    idle_writes();
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = {AW'(i), AW'(i)};
      exp_q.push_back('{$sformatf("sweep_p0_r%0d", i), 32'(i + 10)});
      exp_q.push_back('{$sformatf("sweep_p1_r%0d", i), 32'(i + 10)});
      #1;
      e = exp_q.pop_front(); total++; if (32'(rd_p[7:0])  !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
      e = exp_q.pop_front(); total++; if (32'(rd_p[15:8]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[15:8], e.val); end
    end
    rd_addr = {3'd1, 3'd0};
    exp_q.push_back('{"sweep_zero_r0", 32'h00});
    exp_q.push_back('{"sweep_zero_r1", 32'd11});
    exp_q.push_back('{"sweep_dirty", 32'hFF});
    exp_q.push_back('{"sweep_zero_dirty", 32'hFE});
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_z[7:0])  !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_z[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_z[15:8]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_z[15:8], e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_p)       !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_p, e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_z)       !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_z, e.val); end
    // clr_dirty together with a write: only the written bit survives.
    clr_dirty = 1'b1;
    wa_en = 1'b1; wa_addr = 3'd6; wa_data = 8'h66;
    exp_q.push_back('{"clr_write_dirty", 32'h40});
    exp_q.push_back('{"clr_write_r6", 32'h66});
    step();
    idle_writes();
    rd_addr = {3'd0, 3'd6};
    #1;
    e = exp_q.pop_front(); total++; if (32'(dt_p)      !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_p, e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_async_reset();
    wa_en = 1'b1; wa_addr = 3'd3; wa_data = 8'd99;
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 8'd100;
    step();
    idle_writes();
    rd_addr = {3'd5, 3'd3};
    exp_q.push_back('{"pre_rst_r3", 32'd99});
    exp_q.push_back('{"pre_rst_r5", 32'd100});
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0])  !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_p[15:8]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[15:8], e.val); end
    // Now 2 units after a rising edge: clk high, no edge pending for 3 units.
    reset = 1'b1;
    wa_en = 1'b1; wa_addr = 3'd3; wa_data = 8'h55;
    exp_q.push_back('{"async_rst_r3", 32'd0});
    exp_q.push_back('{"async_rst_r5", 32'd0});
    exp_q.push_back('{"async_rst_dirty", 32'd0});
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0])  !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_p[15:8]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[15:8], e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_p)       !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_p, e.val); end
    // Hold the write through edges while reset stays high.
    step();
    step();
    exp_q.push_back('{"rst_hold_r3", 32'd0});
    exp_q.push_back('{"rst_hold_byp_r3", 32'd0});
    exp_q.push_back('{"rst_hold_dirty", 32'd0});
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(rd_b[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_b[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_p)      !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_p, e.val); end
    // Release: the held write lands on the first edge with reset low.
    reset = 1'b0;
    exp_q.push_back('{"post_rst_r3", 32'h55});
    exp_q.push_back('{"post_rst_dirty", 32'h08});
    step();
    idle_writes();
    #1;
    e = exp_q.pop_front(); total++; if (32'(rd_p[7:0]) !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, rd_p[7:0], e.val); end
    e = exp_q.pop_front(); total++; if (32'(dt_p)      !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dt_p, e.val); end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_bypass();
    test_basic();
    test_conflict();
    test_zero_reg();
    test_sweep();
    test_async_reset();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
